wb_stage: RTL and testbench

//  Write-back end of the MIPS pipeline; consumes what the memory stage emits.

---
 rtl/wb_stage.sv | 88 ++++++++
 tb/tb_wb_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB latch, result select, 2**REG_AW x DATA_W register file
// with two read ports, and a retire counter. Optional macro WB_BYPASS_EN forwards a
// same-cycle commit to the read ports.
module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_address,
    input  logic [REG_AW-1:0] in_write_back_destination,
    input  logic [REG_AW-1:0] rd_addr_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_reg_write,
    output logic [REG_AW-1:0] wb_destination,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retire_count
);
    localparam int NREG = 1 << REG_AW;

    // Flow control: in_valid qualifies the in_* bundle on a cycle; stall=1 freezes
    // the latch and blocks commit, so the held instruction retires exactly once later.
    logic              lat_valid;
    logic              lat_reg_write;
    logic              lat_mem_to_reg;
    logic [DATA_W-1:0] lat_read_data;
    logic [DATA_W-1:0] lat_address;
    logic [REG_AW-1:0] lat_dest;
    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_valid      <= 1'b0;
            lat_reg_write  <= 1'b0;
            lat_mem_to_reg <= 1'b0;
            lat_read_data  <= '0;
            lat_address    <= '0;
            lat_dest       <= '0;
        end else if (!stall) begin
            lat_valid      <= in_valid;
            lat_reg_write  <= in_reg_write;
            lat_mem_to_reg <= in_mem_to_reg;
            lat_read_data  <= in_read_data;
            lat_address    <= in_address;
            lat_dest       <= in_write_back_destination;
        end
    end

    always_comb begin
        wb_data        = lat_mem_to_reg ? lat_read_data : lat_address;
        wb_destination = lat_dest;
        wb_reg_write   = lat_valid && lat_reg_write && (lat_dest != '0) && !stall;
    end

    // Reset wins over a pending commit; register 0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            retire_count <= '0;
        end else if (wb_reg_write) begin
            regs[lat_dest] <= wb_data;
            retire_count   <= retire_count + CNT_W'(1);
        end
    end

    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef WB_BYPASS_EN
        if (wb_reg_write && (rd_addr_a == lat_dest)) begin
            rd_data_a = wb_data;
        end
        if (wb_reg_write && (rd_addr_b == lat_dest)) begin
            rd_data_b = wb_data;
        end
`endif
    end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-instruction vectors plus
// hand-written stall, same-cycle read, reset-during-commit and counter-wrap sequences.
module tb_wb_stage;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, stall, in_reg_write, in_mem_to_reg;
    logic [DATA_W-1:0] in_read_data, in_address;
    logic [REG_AW-1:0] in_write_back_destination, rd_addr_a, rd_addr_b;
    logic [DATA_W-1:0] rd_data_a, rd_data_b, wb_data;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_destination;
    logic [CNT_W-1:0]  retire_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_read_data(in_read_data), .in_address(in_address),
        .in_write_back_destination(in_write_back_destination),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_reg_write(wb_reg_write), .wb_destination(wb_destination),
        .wb_data(wb_data), .retire_count(retire_count)
    );

    typedef struct {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] address;
        logic [REG_AW-1:0] dest;
        logic              exp_write;
        logic [DATA_W-1:0] exp_data;
        logic [DATA_W-1:0] exp_reg;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [DATA_W-1:0] rdat, input logic [DATA_W-1:0] addr,
                         input logic [REG_AW-1:0] dest);
        in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r;
        in_read_data = rdat; in_address = addr; in_write_back_destination = dest;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Latch one ALU-result write, then let it commit on the following edge.
    task automatic commit(input logic [REG_AW-1:0] dest, input logic [DATA_W-1:0] data);
        drive(1'b1, 1'b1, 1'b0, '0, data, dest);
        step();
        bubble();
        step();
        exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_1234, 5'd5,  1'b1, 32'h0000_1234, 32'h0000_1234};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 5'd9,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0040, 5'd0,  1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_0C0C, 5'd12, 1'b0, 32'h0000_0C0C, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0D0D, 5'd13, 1'b0, 32'h0000_0D0D, 32'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h1111_2222, 32'h0000_0005, 5'd5,  1'b1, 32'h1111_2222, 32'h1111_2222};

        rst = 1'b1; stall = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
        bubble();
        exp_cnt = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_retire_count", DATA_W'(retire_count), '0);
        check("rst_wb_reg_write", DATA_W'(wb_reg_write), '0);
        check("rst_wb_destination", DATA_W'(wb_destination), '0);
        check("rst_wb_data", wb_data, '0);
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = REG_AW'(i);
            #1;
            check("rst_rd_data_a", rd_data_a, '0);
        end

        // Table vectors: latch, inspect WB outputs, commit, read back
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].reg_write, vecs[i].mem_to_reg,
                  vecs[i].read_data, vecs[i].address, vecs[i].dest);
            step();
            bubble();
            check("vec_wb_reg_write", DATA_W'(wb_reg_write), DATA_W'(vecs[i].exp_write));
            check("vec_wb_data", wb_data, vecs[i].exp_data);
            check("vec_wb_destination", DATA_W'(wb_destination), DATA_W'(vecs[i].dest));
            if (vecs[i].exp_write) exp_cnt = exp_cnt + 1'b1;
            step();
            rd_addr_a = vecs[i].dest;
            #1;
            check("vec_reg_readback", rd_data_a, vecs[i].exp_reg);
            check("vec_retire_count", DATA_W'(retire_count), DATA_W'(exp_cnt));
        end

        // Stall holds the instruction for 3 cycles, then it commits once
        drive(1'b1, 1'b1, 1'b0, '0, 32'h0000_00A5, 5'd7);
        step();
        bubble();
        stall = 1'b1;
        rd_addr_a = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wb_reg_write", DATA_W'(wb_reg_write), '0);
            check("stall_reg7", rd_data_a, '0);
            check("stall_count", DATA_W'(retire_count), DATA_W'(exp_cnt));
            step();
        end
        stall = 1'b0;
        #1;
        check("unstall_wb_reg_write", DATA_W'(wb_reg_write), 32'd1);
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("unstall_reg7", rd_data_a, 32'h0000_00A5);
        check("unstall_count", DATA_W'(retire_count), DATA_W'(exp_cnt));
        check("unstall_no_recommit", DATA_W'(wb_reg_write), '0);
        step();
        check("unstall_count_once", DATA_W'(retire_count), DATA_W'(exp_cnt));

        // Same-cycle read of the register being committed
        drive(1'b1, 1'b1, 1'b0, '0, 32'h0000_0077, 5'd3);
        step();
        bubble();
        rd_addr_b = 5'd3;
        #1;
        check("samecycle_commit", DATA_W'(wb_reg_write), 32'd1);
`ifdef WB_BYPASS_EN
        check("samecycle_rd_b", rd_data_b, 32'h0000_0077);
`else
        check("samecycle_rd_b", rd_data_b, 32'h0);
`endif
        step();
        exp_cnt = exp_cnt + 1'b1;
        check("aftercommit_rd_b", rd_data_b, 32'h0000_0077);

        // Reset arriving with a commit pending: the write is lost
        drive(1'b1, 1'b1, 1'b0, '0, 32'h0000_0055, 5'd10);
        step();
        bubble();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = '0;
        rd_addr_a = 5'd10;
        #1;
        check("rst_pending_reg10", rd_data_a, '0);
        check("rst_pending_count", DATA_W'(retire_count), '0);
        check("rst_pending_wb_write", DATA_W'(wb_reg_write), '0);

        // Counter wrap from all-ones back to zero
        for (int i = 1; i < (1 << CNT_W); i++) begin
            commit(REG_AW'(i % 31 + 1), DATA_W'(i));
        end
        check("count_all_ones", DATA_W'(retire_count), DATA_W'({CNT_W{1'b1}}));
        commit(5'd20, 32'h0000_BEEF);
        check("count_wrap", DATA_W'(retire_count), '0);
        check("count_model", DATA_W'(retire_count), DATA_W'(exp_cnt));
        rd_addr_a = 5'd20;
        #1;
        check("wrap_reg20", rd_data_a, 32'h0000_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
